// File: rtl/ik_pkg.sv
// Shared fixed-point types, FSM state encoding and the shift/saturate helper
// used by the JJ^T + lambda*I engine.
package ik_pkg;

  localparam int unsigned FIX_W    = 27;
  localparam int unsigned FIX_FRAC = 16;
  localparam int unsigned SAT_W    = 128;

  typedef logic signed [FIX_W-1:0] fix_t;

  localparam fix_t FIX_ONE = FIX_W'(64'd1 << FIX_FRAC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } ik_jjt_state_e;

  typedef struct packed {
    logic signed [SAT_W-1:0] val;
    logic                    sat;
  } sat_res_t;

  // Arithmetic right shift by frac (floor), then clamp into a signed w-bit range.
  function automatic sat_res_t sat_shift(input logic signed [SAT_W-1:0] acc,
                                         input int unsigned frac,
                                         input int unsigned w);
    logic signed [SAT_W-1:0] sh;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t r;
    sh    = acc >>> frac;
    hi    = (SAT_W'(1) <<< (w - 1)) - SAT_W'(1);
    lo    = -hi - SAT_W'(1);
    r.val = sh;
    r.sat = 1'b0;
    if (sh > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (sh < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ik_jjt_bias_seq_if.sv
// Start/busy/done handshake plus Jacobian input and result matrix of the
// JJ^T + lambda*I engine.
interface ik_jjt_bias_seq_if #(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 6,
  parameter int unsigned W    = 27
);
  logic                             start;
  logic [W-1:0]                     lambda;
  logic [ROWS-1:0][COLS-1:0][W-1:0] jacobian;
  logic                             busy;
  logic                             done;
  logic                             overflow;
  logic [ROWS-1:0][ROWS-1:0][W-1:0] jjt_bias;

  modport master (
    output start, lambda, jacobian,
    input  busy, done, overflow, jjt_bias
  );

  modport slave (
    input  start, lambda, jacobian,
    output busy, done, overflow, jjt_bias
  );
endinterface

// File: rtl/ik_mac.sv
// Signed W x W multiply-accumulate with synchronous clear; accumulator is
// sized by the caller so that it never wraps.
module ik_mac
  import ik_pkg::*;
#(
  parameter int unsigned W     = 27,
  parameter int unsigned ACC_W = 58
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr_i,
  input  logic                    acc_en_i,
  input  logic signed [W-1:0]     a_i,
  input  logic signed [W-1:0]     b_i,
  output logic signed [ACC_W-1:0] acc_o
);
  localparam int unsigned PW = 2 * W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_q;

  assign prod = PW'(a_i) * PW'(b_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en) begin
      if (clr_i) begin
        acc_q <= '0;
      end else if (acc_en_i) begin
        acc_q <= acc_q + ACC_W'(prod);
      end
    end
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/ik_jjt_bias_seq.sv
// Time-multiplexed JJ^T + lambda*I: one MAC walks the upper triangle,
// COLS products per element plus one write-back cycle that mirrors the result.
module ik_jjt_bias_seq
  import ik_pkg::*;
#(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 6,
  parameter int unsigned W    = 27,
  parameter int unsigned FRAC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  ik_jjt_bias_seq_if.slave bus
);
  localparam int unsigned ACC_W = 2 * W + $clog2(COLS) + 1;
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned KW    = (COLS > 1) ? $clog2(COLS) : 1;

  ik_jjt_state_e state_q, state_d;
  logic [RW-1:0] i_q, i_d, j_q, j_d;
  logic [KW-1:0] k_q, k_d;
  logic [ROWS-1:0][COLS-1:0][W-1:0] jac_q;
  logic signed [W-1:0]              lam_q;
  logic [ROWS-1:0][ROWS-1:0][W-1:0] res_q;
  logic ovf_q, ovf_d, busy_q, done_q;
  logic load, mac_clr, mac_en, wr_en;
  logic signed [W-1:0]     mac_a, mac_b, wr_val;
  logic signed [ACC_W-1:0] acc, lam_sh, sum;
  sat_res_t                wr_res;

  assign mac_a = jac_q[i_q][k_q];
  assign mac_b = jac_q[j_q][k_q];

  ik_mac #(.W(W), .ACC_W(ACC_W)) u_mac (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr_i    (mac_clr),
    .acc_en_i (mac_en),
    .a_i      (mac_a),
    .b_i      (mac_b),
    .acc_o    (acc)
  );

  // Diagonal bias is lambda aligned to the product's 2*FRAC fraction.
  always_comb begin
    lam_sh = '0;
    if (i_q == j_q) lam_sh = ACC_W'(lam_q) <<< FRAC;
    sum    = acc + lam_sh;
    wr_res = sat_shift(SAT_W'(sum), FRAC, W);
    wr_val = W'(wr_res.val);
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    ovf_d   = ovf_q;
    load    = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          ovf_d   = 1'b0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          mac_clr = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (k_q == KW'(COLS - 1)) begin
          k_d     = '0;
          state_d = ST_WRITE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_WRITE: begin
        wr_en   = 1'b1;
        mac_clr = 1'b1;
        k_d     = '0;
        ovf_d   = ovf_q | wr_res.sat;
        if (i_q == RW'(ROWS - 1) && j_q == RW'(ROWS - 1)) begin
          i_d     = '0;
          j_d     = '0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_MAC;
          // Upper triangle, row-major: next row restarts on its diagonal.
          if (j_q == RW'(ROWS - 1)) begin
            i_d = i_q + 1'b1;
            j_d = i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      jac_q   <= '0;
      lam_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      ovf_q   <= ovf_d;
      busy_q  <= (state_d == ST_MAC) || (state_d == ST_WRITE);
      done_q  <= (state_d == ST_DONE);
      if (load) begin
        jac_q <= bus.jacobian;
        lam_q <= bus.lambda;
      end
      if (wr_en) begin
        res_q[i_q][j_q] <= wr_val;
        res_q[j_q][i_q] <= wr_val;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.jjt_bias = res_q;
endmodule

// File: tb/tb_ik_jjt_bias_seq.sv
// Bench for ik_jjt_bias_seq: directed and random Jacobians checked against a
// plain-arithmetic model of J*J^T + lambda*I with floor shift and clamping.
module tb_ik_jjt_bias_seq;
  localparam int unsigned W = 27;
  localparam longint SAT_HI = 67108863;
  localparam longint SAT_LO = -67108864;

  logic clk = 1'b0;
  logic rst;
  logic en_a;
  logic en_b;

  always #5 clk = ~clk;

  ik_jjt_bias_seq_if #(.ROWS(6), .COLS(6), .W(W)) bus_a ();
  ik_jjt_bias_seq_if #(.ROWS(3), .COLS(4), .W(W)) bus_b ();

  ik_jjt_bias_seq #(.ROWS(6), .COLS(6), .W(W), .FRAC(16)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .bus(bus_a)
  );
  ik_jjt_bias_seq #(.ROWS(3), .COLS(4), .W(W), .FRAC(16)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .bus(bus_b)
  );

  int errors = 0;
  int checks = 0;

  longint jm [6][6];
  longint lam_m;
  longint expm [6][6];
  bit     exp_ovf;
  int     fr, fc;
  longint fgot, fexp;

  task automatic model_calc(input int rows, input int cols);
    longint s;
    exp_ovf = 1'b0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) expm[r][c] = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < rows; c++) begin
        s = 0;
        for (int k = 0; k < cols; k++) s += jm[r][k] * jm[c][k];
        if (r == c) s += lam_m * 65536;
        s = s >>> 16;
        if (s > SAT_HI) begin s = SAT_HI; exp_ovf = 1'b1; end
        if (s < SAT_LO) begin s = SAT_LO; exp_ovf = 1'b1; end
        expm[r][c] = s;
      end
    end
  endtask

  function automatic int diff_mat(input bit use_b);
    int n = 0;
    int rows = use_b ? 3 : 6;
    longint g;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < rows; c++) begin
        g = use_b ? longint'($signed(bus_b.jjt_bias[r][c])) : longint'($signed(bus_a.jjt_bias[r][c]));
        if (g !== expm[r][c]) begin
          if (n == 0) begin fr = r; fc = c; fgot = g; fexp = expm[r][c]; end
          n++;
        end
      end
    end
    return n;
  endfunction

  task automatic clear_jm();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) jm[r][c] = 0;
    lam_m = 0;
  endtask

  task automatic load_a();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) bus_a.jacobian[r][c] = W'(jm[r][c]);
    bus_a.lambda = W'(lam_m);
  endtask

  task automatic load_b();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) bus_b.jacobian[r][c] = W'(jm[r][c]);
    bus_b.lambda = W'(lam_m);
  endtask

  // Starts a run on dut_a and waits for done; returns enabled/total cycle counts.
  task automatic run_a(input int off_at, input int off_len, input int restart_at, input bit rnd_en,
                       output int en_edges, output int tot, output bit busy_ok, output bit timeout);
    repeat (2) @(negedge clk);
    en_a = 1'b1;
    bus_a.start = 1'b1;
    @(posedge clk);
    #1 bus_a.start = 1'b0;
    en_edges = 0;
    tot = 0;
    busy_ok = 1'b1;
    timeout = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(posedge clk);
      tot = c;
      if (en_a) en_edges++;
      #1;
      if (bus_a.done) begin
        timeout = 1'b0;
        break;
      end
      if (!bus_a.busy) busy_ok = 1'b0;
      bus_a.start = (c == restart_at);
      if (rnd_en) en_a = ($urandom_range(0, 3) != 0);
      else        en_a = !(c >= off_at && c < off_at + off_len);
    end
    en_a = 1'b1;
    bus_a.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus_a.busy); end
    checks++;
    if (bus_a.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus_a.done); end
    checks++;
    if (bus_a.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", bus_a.overflow); end
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) expm[r][c] = 0;
    checks++;
    if (diff_mat(1'b0) !== 0) begin errors++; $display("FAIL reset_matrix [%0d][%0d] got=%0d exp=%0d", fr, fc, fgot, fexp); end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    int ee, tot;
    bit bok, to;
    clear_jm();
    for (int r = 0; r < 6; r++) jm[r][r] = 65536;
    lam_m = 32768;
    load_a();
    model_calc(6, 6);
    run_a(0, 0, -1, 1'b0, ee, tot, bok, to);
    checks++;
    if (to || tot !== 147) begin errors++; $display("FAIL ident_latency got=%0d exp=147 timeout=%b", tot, to); end
    checks++;
    if (bok !== 1'b1) begin errors++; $display("FAIL ident_busy_during_run got=%b exp=1", bok); end
    checks++;
    if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL ident_busy_at_done got=%b exp=0", bus_a.busy); end
    checks++;
    if (diff_mat(1'b0) !== 0) begin errors++; $display("FAIL ident_matrix [%0d][%0d] got=%0d exp=%0d", fr, fc, fgot, fexp); end
    checks++;
    if (longint'($signed(bus_a.jjt_bias[3][3])) !== 98304) begin
      errors++; $display("FAIL ident_diag got=%0d exp=98304", $signed(bus_a.jjt_bias[3][3]));
    end
    checks++;
    if (bus_a.overflow !== 1'b0) begin errors++; $display("FAIL ident_overflow got=%b exp=0", bus_a.overflow); end
    @(posedge clk);
    #1;
    checks++;
    if (bus_a.done !== 1'b0) begin errors++; $display("FAIL ident_done_pulse got=%b exp=0", bus_a.done); end
  endtask

  task automatic test_signs();
    int ee, tot;
    bit bok, to, sym;
    clear_jm();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) jm[r][c] = (r == 0) ? -65536 : 65536;
    load_a();
    model_calc(6, 6);
    run_a(0, 0, -1, 1'b0, ee, tot, bok, to);
    checks++;
    if (to || diff_mat(1'b0) !== 0) begin errors++; $display("FAIL signs_matrix [%0d][%0d] got=%0d exp=%0d", fr, fc, fgot, fexp); end
    sym = 1'b1;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) if (bus_a.jjt_bias[r][c] !== bus_a.jjt_bias[c][r]) sym = 1'b0;
    checks++;
    if (sym !== 1'b1) begin errors++; $display("FAIL signs_symmetry got=%b exp=1", sym); end
    checks++;
    if (longint'($signed(bus_a.jjt_bias[0][4])) !== -393216) begin
      errors++; $display("FAIL signs_offdiag got=%0d exp=-393216", $signed(bus_a.jjt_bias[0][4]));
    end
  endtask

  task automatic test_saturate();
    int ee, tot;
    bit bok, to;
    clear_jm();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) jm[r][c] = 33488896;
    load_a();
    model_calc(6, 6);
    run_a(0, 0, -1, 1'b0, ee, tot, bok, to);
    checks++;
    if (to || diff_mat(1'b0) !== 0) begin errors++; $display("FAIL sat_matrix [%0d][%0d] got=%0d exp=%0d", fr, fc, fgot, fexp); end
    checks++;
    if (longint'($signed(bus_a.jjt_bias[2][5])) !== SAT_HI) begin
      errors++; $display("FAIL sat_value got=%0d exp=%0d", $signed(bus_a.jjt_bias[2][5]), SAT_HI);
    end
    checks++;
    if (bus_a.overflow !== 1'b1) begin errors++; $display("FAIL sat_overflow got=%b exp=1", bus_a.overflow); end
    clear_jm();
    for (int r = 0; r < 6; r++) jm[r][r] = 65536;
    load_a();
    model_calc(6, 6);
    run_a(0, 0, -1, 1'b0, ee, tot, bok, to);
    checks++;
    if (to || bus_a.overflow !== 1'b0) begin errors++; $display("FAIL sat_overflow_cleared got=%b exp=0", bus_a.overflow); end
  endtask

  task automatic test_en_gap();
    int ee, tot;
    bit bok, to;
    clear_jm();
    for (int r = 0; r < 6; r++) jm[r][r] = 65536;
    lam_m = 32768;
    load_a();
    model_calc(6, 6);
    run_a(60, 10, 80, 1'b0, ee, tot, bok, to);
    checks++;
    if (to || tot !== 157) begin errors++; $display("FAIL engap_latency got=%0d exp=157 timeout=%b", tot, to); end
    checks++;
    if (bok !== 1'b1) begin errors++; $display("FAIL engap_busy got=%b exp=1", bok); end
    checks++;
    if (diff_mat(1'b0) !== 0) begin errors++; $display("FAIL engap_matrix [%0d][%0d] got=%0d exp=%0d", fr, fc, fgot, fexp); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL engap_restart_ignored busy=%b exp=0", bus_a.busy); end
  endtask

  task automatic test_reset_midrun();
    int ee, tot, seen;
    bit bok, to;
    clear_jm();
    for (int r = 0; r < 6; r++) jm[r][r] = 65536;
    lam_m = 32768;
    load_a();
    repeat (2) @(negedge clk);
    bus_a.start = 1'b1;
    @(posedge clk);
    #1 bus_a.start = 1'b0;
    repeat (49) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus_a.busy); end
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) expm[r][c] = 0;
    checks++;
    if (diff_mat(1'b0) !== 0) begin errors++; $display("FAIL midrst_matrix [%0d][%0d] got=%0d exp=%0d", fr, fc, fgot, fexp); end
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (bus_a.done) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
    model_calc(6, 6);
    run_a(0, 0, -1, 1'b0, ee, tot, bok, to);
    checks++;
    if (to || tot !== 147) begin errors++; $display("FAIL midrst_rerun_latency got=%0d exp=147", tot); end
    checks++;
    if (diff_mat(1'b0) !== 0) begin errors++; $display("FAIL midrst_rerun_matrix [%0d][%0d] got=%0d exp=%0d", fr, fc, fgot, fexp); end
  endtask

  task automatic test_small();
    int tot;
    bit to;
    clear_jm();
    jm[0][0] = 65536;
    jm[1][1] = 131072;
    jm[2][0] = 65536;
    jm[2][1] = 65536;
    load_b();
    model_calc(3, 4);
    repeat (2) @(negedge clk);
    bus_b.start = 1'b1;
    @(posedge clk);
    #1 bus_b.start = 1'b0;
    tot = 0;
    to = 1'b1;
    for (int c = 1; c <= 500; c++) begin
      @(posedge clk);
      #1;
      if (bus_b.done) begin tot = c; to = 1'b0; break; end
    end
    checks++;
    if (to || tot !== 30) begin errors++; $display("FAIL small_latency got=%0d exp=30 timeout=%b", tot, to); end
    checks++;
    if (diff_mat(1'b1) !== 0) begin errors++; $display("FAIL small_matrix [%0d][%0d] got=%0d exp=%0d", fr, fc, fgot, fexp); end
    checks++;
    if (longint'($signed(bus_b.jjt_bias[1][2])) !== 131072) begin
      errors++; $display("FAIL small_12 got=%0d exp=131072", $signed(bus_b.jjt_bias[1][2]));
    end
  endtask

  task automatic test_random();
    int ee, tot;
    bit bok, to, big;
    for (int run = 0; run < 6; run++) begin
      big = (run == 4);
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++)
          jm[r][c] = big ? longint'($urandom_range(0, 134217726)) - 67108863
                         : longint'($urandom_range(0, 2097152)) - 1048576;
      lam_m = longint'($urandom_range(0, 524288)) - 262144;
      load_a();
      model_calc(6, 6);
      run_a(0, 0, -1, 1'b1, ee, tot, bok, to);
      checks++;
      if (to || ee !== 147) begin errors++; $display("FAIL rand%0d_latency enabled=%0d exp=147 timeout=%b", run, ee, to); end
      checks++;
      if (diff_mat(1'b0) !== 0) begin errors++; $display("FAIL rand%0d_matrix [%0d][%0d] got=%0d exp=%0d", run, fr, fc, fgot, fexp); end
      checks++;
      if (bus_a.overflow !== exp_ovf) begin errors++; $display("FAIL rand%0d_overflow got=%b exp=%b", run, bus_a.overflow, exp_ovf); end
    end
  endtask

  initial begin
    rst = 1'b1;
    en_a = 1'b1;
    en_b = 1'b1;
    bus_a.start = 1'b0;
    bus_a.lambda = '0;
    bus_a.jacobian = '0;
    bus_b.start = 1'b0;
    bus_b.lambda = '0;
    bus_b.jacobian = '0;
    test_reset();
    test_identity();
    test_signs();
    test_saturate();
    test_en_gap();
    test_reset_midrun();
    test_small();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ik_jjt_bias_seq.md
Name: ik_jjt_bias_seq

Overview:
Parametrised, time-multiplexed engine that computes JJT_BIAS = J * J^T + lambda * I for an ROWS x COLS Jacobian in signed fixed point. It generalises the fixed 6-joint, combinational jjt_bias stage of the IK pipeline. Dimensions, word width and fraction bits are configurable, and it adds a start/busy/done handshake, a clock enable and saturation with an overflow flag. It sits between the Jacobian stage and the LT decomposition stage of ik_swift.

Parameters:
ROWS, 6, rows of J (task-space dimension); result is ROWS x ROWS
COLS, 6, columns of J (joint count)
W, 27, word width, signed two's complement
FRAC, 16, fractional bits (1.0 = 2^FRAC)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
en  input  1  clock enable; when low all state, including counters, holds
start  input  1  request computation; sampled only in IDLE
lambda  input  W  damping bias added to diagonal; latched on start
jacobian  input  [ROWS-1:0][COLS-1:0][W-1:0]  J; latched on start
busy  output  1  high in MAC and WRITE states
done  output  1  one-cycle pulse when result complete
overflow  output  1  sticky; set if any element saturated during current run
jjt_bias  output  [ROWS-1:0][ROWS-1:0][W-1:0]  result matrix, registered

Behaviour:
- Reset, when rst=1 at a posedge, regardless of en or state:
  - state=IDLE; busy=0, done=0, overflow=0.
  - jjt_bias all zero; counters i, j, k zero; accumulator zero.
- States: IDLE, MAC, WRITE, DONE. All transitions require en=1.
- IDLE:
  - start=1 latches jacobian and lambda, clears overflow, sets i=0, j=0, k=0, acc=0 and moves to MAC.
  - start in any other state is ignored, including the DONE cycle.
- MAC:
  - acc += J[i][k] * J[j][k], using a full 2W-bit product.
  - Accumulator width is 2W + clog2(COLS) + 1; it never wraps.
  - k increments each cycle. After the k=COLS-1 cycle, go to WRITE.
- WRITE:
  - If i==j, add sign-extended lambda << FRAC to acc.
  - r = acc >>> FRAC (arithmetic shift, truncation toward -inf).
  - Saturate r to [-2^(W-1), 2^(W-1)-1]. If saturated, set overflow.
  - Write r to jjt_bias[i][j] and jjt_bias[j][i] in the same cycle.
  - Clear acc and k, then advance the pair over the upper triangle, row-major: j++; if j==ROWS then i++, j=i.
  - If the pair just written was (ROWS-1, ROWS-1), go to DONE; otherwise go to MAC.
- DONE: done=1 for exactly this cycle, busy=0, then go to IDLE.
- Latency:
  - P = ROWS*(ROWS+1)/2 element pairs, COLS+1 cycles each.
  - done is high in the cycle P*(COLS+1) enabled cycles after the start-acceptance edge.
  - Default configuration: 21 pairs x 7 = 147 cycles.
  - Each en=0 cycle extends latency by one cycle.
- Output validity:
  - jjt_bias is valid from the done cycle until the next start is accepted.
  - During a run, entries update pair by pair. Consumers must not sample the result while busy=1.
- Input latching: jacobian and lambda may change freely after start is accepted.
- Reset mid-run aborts immediately. No done pulse is produced and the result is zeroed.

Decomposition:
- Shared package ik_pkg holds:
  - fix_t typedef, parameterised via W.
  - Function sat_shift(acc, FRAC, W) returning result and saturation flag.
  - FIX_ONE constant.
  - State enum ik_jjt_state_e.
- One sub-module, ik_mac: a signed W x W multiply-accumulate with clear input and enable, holding acc.
- The FSM, counters and write-back stay in ik_jjt_bias_seq.

Test Plan:
Unless stated otherwise, scenarios use the default parameters, where 1.0 = 65536.
1. J=identity (6x6), lambda=32768 (0.5) -> diagonal 98304, off-diagonal 0, overflow=0. done exactly 147 cycles after start edge; busy high for the 146 preceding cycles.
2. Row 0 all -65536, other rows all +65536, lambda=0 -> [0][0]=393216; [0][j]=[j][0]=-393216 for j>0; remaining entries 393216; matrix symmetric.
3. All entries 511.0 (33488896) -> every element saturates to 67108863; overflow=1. A follow-up run with identity J clears overflow to 0.
4. Identity J, en low for 10 cycles mid-run, start re-pulsed while busy -> done at cycle 157, results identical to scenario 1, second start ignored.
5. rst asserted at cycle 50 of a run -> next cycle busy=0, done never pulses, jjt_bias all 0; a new start then completes normally in 147 cycles.
6. ROWS=3, COLS=4, W=27, FRAC=16, J rows (1,0,0,0), (0,2,0,0), (1,1,0,0) in real units, lambda=0 -> diagonal 1, 4, 2; [0][2]=1, [1][2]=2, [0][1]=0 (each x65536); done at 30 cycles.
